// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store on a word array with programmable wait states.
// Optional address checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_resp_valid;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_err;
  logic             w_access;
  logic             w_unused;

  assign w_off    = r_addr - BASE_ADDR;
  assign w_idx    = w_off[IDX_W+1:2];
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_unused = ^{w_off[1:0], w_off[31:IDX_W+2]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_err = (r_addr[1:0] != 2'b00) || (r_addr < BASE_ADDR) ||
                 ((w_off >> 2) >= 32'(DEPTH_WORDS));
`else
  assign w_err = 1'b0;
`endif

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  // The counter is loaded with WAIT_STATES so the access edge lands WAIT_STATES+1 edges after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_write      <= 1'b0;
      r_addr       <= 32'd0;
      r_wdata      <= 32'd0;
      r_resp_valid <= 1'b0;
      r_rdata      <= 32'd0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cnt   <= 4'(WAIT_STATES);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_err;
            r_rdata      <= (r_write || w_err) ? 32'd0 : r_mem[w_idx];
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Array is not reset; a reset coinciding with the access edge aborts the store.
  always_ff @(posedge clk) begin
    if (!rst && w_access && r_write && !w_err) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: default instance plus a zero-wait-state instance
// with a non-zero base address, directed table, corner-case sequences and randomized traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;

  logic        a_req_ready, a_resp_valid, a_resp_err;
  logic [31:0] a_resp_rdata;
  logic        b_req_ready, b_resp_valid, b_resp_err;
  logic [31:0] b_resp_rdata;

  logic        w_rr, w_rv, w_er;
  logic [31:0] w_rd;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [16];

  always #5 clk = ~clk;

  dmem_responder u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && !sel), .req_ready(a_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready && !sel),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0100)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid && sel), .req_ready(b_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready && sel),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  assign w_rr = sel ? b_req_ready  : a_req_ready;
  assign w_rv = sel ? b_resp_valid : a_resp_valid;
  assign w_rd = sel ? b_resp_rdata : a_resp_rdata;
  assign w_er = sel ? b_resp_err   : a_resp_err;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          stall;
    logic [31:0] exp_rd;
    bit          exp_er;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_err(input logic [31:0] addr, input logic [31:0] base, input int depth);
`ifdef DMEM_ALIGN_CHECK_EN
    return (addr[1:0] != 2'b00) || (addr < base) || (((addr - base) >> 2) >= 32'(depth));
`else
    return 1'b0;
`endif
  endfunction

  // Reference: word index is the byte offset from base in words, wrapped to the array size.
  task automatic model(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
    logic [31:0] base;
    int          depth;
    int          idx;
    base  = sel ? 32'h100 : 32'h0;
    depth = sel ? 16 : 256;
    er    = m_err(addr, base, depth);
    idx   = int'(((addr - base) >> 2) % 32'(depth));
    rd    = 32'd0;
    if (!er) begin
      if (wr) begin
        if (sel) mem_b[idx] = wd; else mem_a[idx] = wd;
      end else begin
        rd = sel ? mem_b[idx] : mem_a[idx];
      end
    end
  endtask

  // Called at a negedge; returns at a negedge after the response handshake.
  task automatic txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd, input int stall,
                     output logic [31:0] rd, output logic er);
    int          n;
    int          lat;
    logic [31:0] rd0;
    logic        er0;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    resp_ready = 1'b0;
    n = 0;
    while (!w_rr && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, w_rr}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = 0;
    while (!w_rv && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), sel ? 32'd1 : 32'd3);
    rd0 = w_rd;
    er0 = w_er;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = (i == 0) ? 32'h20 : ($urandom & 32'h3FC);
      req_wdata = $urandom;
      @(negedge clk);
      chk("hold_valid", {31'd0, w_rv}, 32'd1);
      chk("hold_rdata", w_rd, rd0);
      chk("hold_err", {31'd0, w_er}, {31'd0, er0});
      chk("hold_ready", {31'd0, w_rr}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    rd = w_rd;
    er = w_er;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", {31'd0, w_rv}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, erd;
    logic        er, eer;
    logic [31:0] addr;
    bit          wr;
    int          seen;

    sel = 1'b0; rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

    tbl.push_back('{wr:1, addr:32'h10, wd:32'hDEADBEEF, stall:0, exp_rd:32'h0, exp_er:0});
    tbl.push_back('{wr:0, addr:32'h10, wd:32'h0, stall:0, exp_rd:32'hDEADBEEF, exp_er:0});
    tbl.push_back('{wr:1, addr:32'h20, wd:32'h20202020, stall:1, exp_rd:32'h0, exp_er:0});
    tbl.push_back('{wr:0, addr:32'h20, wd:32'h0, stall:2, exp_rd:32'h20202020, exp_er:0});
    tbl.push_back('{wr:1, addr:32'h0, wd:32'h00001111, stall:0, exp_rd:32'h0, exp_er:0});
`ifdef DMEM_ALIGN_CHECK_EN
    tbl.push_back('{wr:1, addr:32'h12, wd:32'hAAAA5555, stall:0, exp_rd:32'h0, exp_er:1});
    tbl.push_back('{wr:0, addr:32'h10, wd:32'h0, stall:0, exp_rd:32'hDEADBEEF, exp_er:0});
    tbl.push_back('{wr:0, addr:32'h400, wd:32'h0, stall:1, exp_rd:32'h0, exp_er:1});
    tbl.push_back('{wr:1, addr:32'h400, wd:32'h12345678, stall:0, exp_rd:32'h0, exp_er:1});
    tbl.push_back('{wr:0, addr:32'h0, wd:32'h0, stall:0, exp_rd:32'h00001111, exp_er:0});
`else
    tbl.push_back('{wr:1, addr:32'h400, wd:32'h12345678, stall:0, exp_rd:32'h0, exp_er:0});
    tbl.push_back('{wr:0, addr:32'h0, wd:32'h0, stall:0, exp_rd:32'h12345678, exp_er:0});
    tbl.push_back('{wr:1, addr:32'h13, wd:32'hCAFEF00D, stall:0, exp_rd:32'h0, exp_er:0});
    tbl.push_back('{wr:0, addr:32'h10, wd:32'h0, stall:0, exp_rd:32'hCAFEF00D, exp_er:0});
    tbl.push_back('{wr:0, addr:32'h11, wd:32'h0, stall:1, exp_rd:32'hCAFEF00D, exp_er:0});
`endif
    tbl.push_back('{wr:1, addr:32'h10, wd:32'hDEADBEEF, stall:0, exp_rd:32'h0, exp_er:0});

    // Reset behaviour on both instances
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready_a", {31'd0, a_req_ready}, 32'd0);
      chk("rst_valid_a", {31'd0, a_resp_valid}, 32'd0);
      chk("rst_rdata_a", a_resp_rdata, 32'd0);
      chk("rst_err_a", {31'd0, a_resp_err}, 32'd0);
      chk("rst_valid_b", {31'd0, b_resp_valid}, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("post_rst_ready_a", {31'd0, a_req_ready}, 32'd1);
    chk("post_rst_ready_b", {31'd0, b_req_ready}, 32'd1);
    @(negedge clk);

    // Known contents in both arrays
    sel = 1'b0;
    for (int i = 0; i < 256; i++) begin
      txn(1'b1, 32'(i * 4), 32'hA500_0000 + 32'(i), 0, rd, er);
      model(1'b1, 32'(i * 4), 32'hA500_0000 + 32'(i), erd, eer);
    end
    sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      txn(1'b1, 32'h100 + 32'(i * 4), 32'hB600_0000 + 32'(i), 0, rd, er);
      model(1'b1, 32'h100 + 32'(i * 4), 32'hB600_0000 + 32'(i), erd, eer);
    end

    // Directed table on the default instance
    sel = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].stall, rd, er);
      chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_er});
      model(tbl[i].wr, tbl[i].addr, tbl[i].wd, erd, eer);
    end

    // Backpressure with a competing request to 0x20
    txn(1'b0, 32'h10, 32'h0, 5, rd, er);
    chk("bp_rdata", rd, 32'hDEADBEEF);
    chk("bp_ready_after", {31'd0, w_rr}, 32'd1);
    txn(1'b0, 32'h20, 32'h0, 0, rd, er);
    chk("bp_0x20_untouched", rd, 32'h20202020);

    // Reset during the second wait cycle aborts the store
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0BADF00D; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (a_resp_valid) seen++;
      @(negedge clk);
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 0, rd, er);
    chk("abort_old_value", rd, 32'h20202020);

    // Zero-wait-state instance
    sel = 1'b1;
    txn(1'b1, 32'h104, 32'h5A5A_C3C3, 0, rd, er);
    model(1'b1, 32'h104, 32'h5A5A_C3C3, erd, eer);
    chk("ws0_store_rdata", rd, 32'd0);
    txn(1'b0, 32'h104, 32'h0, 1, rd, er);
    model(1'b0, 32'h104, 32'h0, erd, eer);
    chk("ws0_load_rdata", rd, 32'h5A5A_C3C3);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      int r;
      sel = 1'($urandom);
      wr  = 1'($urandom);
      r   = int'($urandom_range(0, 7));
      if (!sel) begin
        addr = (r < 5) ? ($urandom_range(0, 1023) & 32'hFFFF_FFFC)
             : (r == 5) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 32'hFFFF));
      end else begin
        addr = 32'hE0 + 32'($urandom_range(0, 159));
        if (r < 5) addr = addr & 32'hFFFF_FFFC;
      end
      req_wdata = $urandom;
      begin
        logic [31:0] wd;
        wd = $urandom;
        txn(wr, addr, wd, int'($urandom_range(0, 3)), rd, er);
        model(wr, addr, wd, erd, eer);
      end
      chk($sformatf("rnd%0d_rdata@%h", i, addr), rd, erd);
      chk($sformatf("rnd%0d_err@%h", i, addr), {31'd0, er}, {31'd0, eer});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
